// File: rtl/mac_tx_framer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_tx_framer_if
//  Purpose  : Byte-wide valid/ready payload stream feeding mac_tx_framer.
//  Revision : 1.0
// ============================================================================
interface mac_tx_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_error;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        output tx_error,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        input  tx_error,
        output tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/mac_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module   : mac_tx_framer
//  Purpose  : GMII transmit framer: preamble, SFD, payload, optional zero pad
//             (compiled in with MAC_TX_PAD_EN), CRC-32 FCS and inter-frame gap.
//  Revision : 1.0
// ============================================================================
module mac_tx_framer #(
    parameter int IFG_BYTES = 12,
    parameter int MIN_FRAME = 60
) (
    input  logic             clock_125MHz,
    input  logic             reset,
    mac_tx_framer_if.slave   tx,
    output logic [7:0]       mac_txd,
    output logic             mac_tx_en,
    output logic             mac_tx_er,
    output logic             tx_done,
    output logic             tx_underrun
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_IFG      = 3'd6,
        ST_DRAIN    = 3'd7
    } state_t;

    localparam logic [31:0] c_crc_poly  = 32'hEDB88320;
    localparam logic [31:0] c_crc_init  = 32'hFFFF_FFFF;
    localparam logic [15:0] c_ifg_last  = 16'(IFG_BYTES - 1);
    localparam logic [10:0] c_min_frame = 11'(MIN_FRAME);
`ifdef MAC_TX_PAD_EN
    localparam bit          c_pad_en    = 1'b1;
`else
    localparam bit          c_pad_en    = 1'b0;
`endif

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ c_crc_poly) : (c >> 1);
        end
        return c;
    endfunction

    state_t      state_q,    state_d;
    logic [15:0] phase_q,    phase_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q,      crc_d;
    logic [7:0]  txd_q,      txd_d;
    logic        tx_en_q,    tx_en_d;
    logic        tx_er_q,    tx_er_d;
    logic        done_q,     done_d;
    logic        underrun_q, underrun_d;

    logic        w_accept;
    logic [10:0] w_cnt_inc;
    logic [31:0] w_fcs;

    assign tx.tx_ready = (state_q == ST_DATA) || (state_q == ST_DRAIN);
    assign w_accept    = tx.tx_valid & tx.tx_ready;
    assign w_cnt_inc   = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign w_fcs       = ~crc_q;

    // State decides what the output flops load for the next wire cycle, so the
    // state machine runs one cycle ahead of mac_txd.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        txd_d      = 8'h00;
        tx_en_d    = 1'b0;
        tx_er_d    = 1'b0;
        done_d     = 1'b0;
        underrun_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx.tx_valid) begin
                    state_d = ST_PREAMBLE;
                    phase_d = 16'd0;
                    txd_d   = 8'h55;
                    tx_en_d = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                txd_d   = 8'h55;
                tx_en_d = 1'b1;
                if (phase_q == 16'd5) begin
                    state_d = ST_SFD;
                    phase_d = 16'd0;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            ST_SFD: begin
                txd_d      = 8'hD5;
                tx_en_d    = 1'b1;
                crc_d      = c_crc_init;
                byte_cnt_d = 11'd0;
                state_d    = ST_DATA;
            end
            ST_DATA: begin
                tx_en_d = 1'b1;
                if (tx.tx_valid) begin
                    txd_d      = tx.tx_data;
                    tx_er_d    = tx.tx_error;
                    crc_d      = crc32_byte(crc_q, tx.tx_data);
                    byte_cnt_d = w_cnt_inc;
                    if (tx.tx_last) begin
                        phase_d = 16'd0;
                        state_d = (c_pad_en && (w_cnt_inc < c_min_frame)) ? ST_PAD : ST_FCS;
                    end
                end else begin
                    tx_er_d    = 1'b1;
                    underrun_d = 1'b1;
                    state_d    = ST_DRAIN;
                end
            end
`ifdef MAC_TX_PAD_EN
            ST_PAD: begin
                tx_en_d    = 1'b1;
                crc_d      = crc32_byte(crc_q, 8'h00);
                byte_cnt_d = w_cnt_inc;
                if (w_cnt_inc >= c_min_frame) begin
                    state_d = ST_FCS;
                    phase_d = 16'd0;
                end
            end
`endif
            ST_FCS: begin
                txd_d   = w_fcs[{phase_q[1:0], 3'b000} +: 8];
                tx_en_d = 1'b1;
                if (phase_q == 16'd3) begin
                    state_d = ST_IFG;
                    phase_d = 16'd0;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            ST_IFG: begin
                done_d = (phase_q == 16'd0);
                if (phase_q >= c_ifg_last) begin
                    state_d = ST_IDLE;
                    phase_d = 16'd0;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            ST_DRAIN: begin
                if (w_accept && tx.tx_last) begin
                    state_d = ST_IFG;
                    phase_d = 16'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_125MHz or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= 16'd0;
            byte_cnt_q <= 11'd0;
            crc_q      <= c_crc_init;
            txd_q      <= 8'h00;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            txd_q      <= txd_d;
            tx_en_q    <= tx_en_d;
            tx_er_q    <= tx_er_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign mac_txd     = txd_q;
    assign mac_tx_en   = tx_en_q;
    assign mac_tx_er   = tx_er_q;
    assign tx_done     = done_q;
    assign tx_underrun = underrun_q;

endmodule
`default_nettype wire
